// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing generator: sync pulses, one-clock-early pixel requests and gated RGB.
// Optional FRAME_CNT_EN adds an 8-bit frame index output that steps with frame_start.
module vga_timing_ctrl #(
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BACK  = 48,
   parameter int unsigned H_VALID = 640,
   parameter int unsigned H_FRONT = 16,
   parameter int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BACK  = 33,
   parameter int unsigned V_VALID = 480,
   parameter int unsigned V_FRONT = 10,
   parameter int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT
) (
   input  logic        i_vga_clk,
   input  logic        i_rst,
   input  logic [11:0] i_pix_data,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic [11:0] o_rgb,
   output logic [9:0]  o_pix_x,
   output logic [9:0]  o_pix_y,
   output logic        o_pix_req,
   output logic        o_frame_start
`ifdef FRAME_CNT_EN
   ,
   output logic [7:0]  o_frame_cnt
`endif
);

   localparam logic [9:0] LP_H_END     = 10'(H_TOTAL - 1);
   localparam logic [9:0] LP_V_END     = 10'(V_TOTAL - 1);
   localparam logic [9:0] LP_H_SYNC    = 10'(H_SYNC);
   localparam logic [9:0] LP_V_SYNC    = 10'(V_SYNC);
   localparam logic [9:0] LP_H_ACT_BEG = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] LP_H_ACT_END = 10'(H_SYNC + H_BACK + H_VALID);
   // Requests lead the visible window by one clock to cover the display stage's register.
   localparam logic [9:0] LP_H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
   localparam logic [9:0] LP_H_REQ_END = 10'(H_SYNC + H_BACK + H_VALID - 1);
   localparam logic [9:0] LP_V_ACT_BEG = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] LP_V_ACT_END = 10'(V_SYNC + V_BACK + V_VALID);

   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;
   logic       r_frame_start;
`ifdef FRAME_CNT_EN
   logic [7:0] r_frame_cnt;
`endif

   logic w_h_end;
   logic w_v_end;
   logic w_h_act;
   logic w_h_req;
   logic w_v_act;
   logic w_rgb_valid;

   assign w_h_end = (r_h_cnt == LP_H_END);
   assign w_v_end = (r_v_cnt == LP_V_END);

   always_ff @(posedge i_vga_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h_cnt       <= 10'd0;
         r_v_cnt       <= 10'd0;
         r_frame_start <= 1'b0;
`ifdef FRAME_CNT_EN
         r_frame_cnt   <= 8'd0;
`endif
      end else begin
         r_frame_start <= 1'b0;
         if (w_h_end) begin
            r_h_cnt <= 10'd0;
            if (w_v_end) begin
               r_v_cnt       <= 10'd0;
               r_frame_start <= 1'b1;
`ifdef FRAME_CNT_EN
               r_frame_cnt   <= r_frame_cnt + 8'd1;
`endif
            end else begin
               r_v_cnt <= r_v_cnt + 10'd1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   assign w_h_act     = (r_h_cnt >= LP_H_ACT_BEG) && (r_h_cnt < LP_H_ACT_END);
   assign w_h_req     = (r_h_cnt >= LP_H_REQ_BEG) && (r_h_cnt < LP_H_REQ_END);
   assign w_v_act     = (r_v_cnt >= LP_V_ACT_BEG) && (r_v_cnt < LP_V_ACT_END);
   assign w_rgb_valid = w_h_act && w_v_act;

   always_comb begin
      o_hsync   = 1'b1;
      o_vsync   = 1'b1;
      o_pix_req = 1'b0;
      o_pix_x   = 10'h3FF;
      o_pix_y   = 10'h3FF;
      o_rgb     = 12'h000;
      if (r_h_cnt < LP_H_SYNC) o_hsync = 1'b0;
      if (r_v_cnt < LP_V_SYNC) o_vsync = 1'b0;
      if (w_h_req && w_v_act) begin
         o_pix_req = 1'b1;
         o_pix_x   = r_h_cnt - LP_H_REQ_BEG;
         o_pix_y   = r_v_cnt - LP_V_ACT_BEG;
      end
      if (w_rgb_valid) o_rgb = i_pix_data;
   end

   assign o_frame_start = r_frame_start;
`ifdef FRAME_CNT_EN
   assign o_frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance and a tiny-mode instance checked every cycle
// against an arithmetic model driven by the clock count since reset release.
module tb_vga_timing_ctrl;

   typedef struct {
      longint unsigned hs, hb, hv, hf, vs, vb, vv, vf;
   } mode_t;

   typedef struct {
      logic       hsync, vsync, req, valid, fs;
      logic [9:0] px, py;
      logic [7:0] fc;
   } exp_t;

   mode_t m_big = '{96, 48, 640, 16, 2, 33, 480, 10};
   mode_t m_sml = '{2, 2, 4, 2, 1, 2, 3, 1};

   logic        clk;
   logic        rst;
   logic [11:0] pix_big;
   logic [11:0] pix_sml;

   logic        b_hsync, b_vsync, b_req, b_fs;
   logic [11:0] b_rgb;
   logic [9:0]  b_px, b_py;
   logic        s_hsync, s_vsync, s_req, s_fs;
   logic [11:0] s_rgb;
   logic [9:0]  s_px, s_py;
`ifdef FRAME_CNT_EN
   logic [7:0]  b_fc, s_fc;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   longint unsigned t = 0;
   int hs_low_cnt = 0;
   int req_cnt    = 0;

   vga_timing_ctrl u_dut_big (
      .i_vga_clk     (clk),
      .i_rst         (rst),
      .i_pix_data    (pix_big),
      .o_hsync       (b_hsync),
      .o_vsync       (b_vsync),
      .o_rgb         (b_rgb),
      .o_pix_x       (b_px),
      .o_pix_y       (b_py),
      .o_pix_req     (b_req),
      .o_frame_start (b_fs)
`ifdef FRAME_CNT_EN
      ,
      .o_frame_cnt   (b_fc)
`endif
   );

   vga_timing_ctrl #(
      .H_SYNC  (2),
      .H_BACK  (2),
      .H_VALID (4),
      .H_FRONT (2),
      .V_SYNC  (1),
      .V_BACK  (2),
      .V_VALID (3),
      .V_FRONT (1)
   ) u_dut_sml (
      .i_vga_clk     (clk),
      .i_rst         (rst),
      .i_pix_data    (pix_sml),
      .o_hsync       (s_hsync),
      .o_vsync       (s_vsync),
      .o_rgb         (s_rgb),
      .o_pix_x       (s_px),
      .o_pix_y       (s_py),
      .o_pix_req     (s_req),
      .o_frame_start (s_fs)
`ifdef FRAME_CNT_EN
      ,
      .o_frame_cnt   (s_fc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // t counts clock edges since reset was last released; every output is a function of it.
   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   function automatic exp_t model(mode_t m, longint unsigned tt);
      exp_t e;
      longint unsigned ht, vt, h, v, hab, vab;
      logic vact;
      ht   = m.hs + m.hb + m.hv + m.hf;
      vt   = m.vs + m.vb + m.vv + m.vf;
      h    = tt % ht;
      v    = (tt / ht) % vt;
      hab  = m.hs + m.hb;
      vab  = m.vs + m.vb;
      vact = (v >= vab) && (v < vab + m.vv);
      e.hsync = (h >= m.hs);
      e.vsync = (v >= m.vs);
      e.valid = vact && (h >= hab) && (h < hab + m.hv);
      e.req   = vact && (h + 1 >= hab) && (h + 1 < hab + m.hv);
      e.px    = e.req ? 10'(h + 1 - hab) : 10'h3FF;
      e.py    = e.req ? 10'(v - vab) : 10'h3FF;
      e.fs    = (tt != 0) && (tt % (ht * vt) == 0);
      e.fc    = 8'((tt / (ht * vt)) % 256);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t eb, es;
      longint unsigned hb_now, vb_now;
      eb = model(m_big, t);
      es = model(m_sml, t);
      check("big_hsync", 32'(b_hsync), 32'(eb.hsync));
      check("big_vsync", 32'(b_vsync), 32'(eb.vsync));
      check("big_req",   32'(b_req),   32'(eb.req));
      check("big_px",    32'(b_px),    32'(eb.px));
      check("big_py",    32'(b_py),    32'(eb.py));
      check("big_rgb",   32'(b_rgb),   32'(eb.valid ? pix_big : 12'h000));
      check("big_fs",    32'(b_fs),    32'(eb.fs));
      check("sml_hsync", 32'(s_hsync), 32'(es.hsync));
      check("sml_vsync", 32'(s_vsync), 32'(es.vsync));
      check("sml_req",   32'(s_req),   32'(es.req));
      check("sml_px",    32'(s_px),    32'(es.px));
      check("sml_py",    32'(s_py),    32'(es.py));
      check("sml_rgb",   32'(s_rgb),   32'(es.valid ? pix_sml : 12'h000));
      check("sml_fs",    32'(s_fs),    32'(es.fs));
`ifdef FRAME_CNT_EN
      check("big_fc", 32'(b_fc), 32'(eb.fc));
      check("sml_fc", 32'(s_fc), 32'(es.fc));
      if (t == 255 * 70) check("pin_fc_255", 32'(s_fc), 32'd255);
      if (t == 256 * 70) check("pin_fc_wrap", 32'(s_fc), 32'd0);
      if (t == 257 * 70) check("pin_fc_one", 32'(s_fc), 32'd1);
`endif

      // Hand-computed anchors for the full-size mode.
      if (rst) begin
         check("pin_rst_px",    32'(b_px),    32'h3FF);
         check("pin_rst_hsync", 32'(b_hsync), 32'd0);
         check("pin_rst_vsync", 32'(b_vsync), 32'd0);
         check("pin_rst_rgb",   32'(b_rgb),   32'd0);
      end
      if (t == 95)              check("pin_hsync_last_low", 32'(b_hsync), 32'd0);
      if (t == 96)              check("pin_hsync_high",     32'(b_hsync), 32'd1);
      if (t == 1599)            check("pin_vsync_last_low", 32'(b_vsync), 32'd0);
      if (t == 1600)            check("pin_vsync_high",     32'(b_vsync), 32'd1);
      if (t == 34 * 800 + 500)  check("pin_rgb_v34",        32'(b_rgb),   32'd0);
      if (t == 35 * 800 + 143)  check("pin_first_px",       32'(b_px),    32'd0);
      if (t == 35 * 800 + 143)  check("pin_first_py",       32'(b_py),    32'd0);
      if (t == 35 * 800 + 782)  check("pin_last_px",        32'(b_px),    32'd639);
      if (t == 35 * 800 + 783)  check("pin_783_req",        32'(b_req),   32'd0);
      if (t == 35 * 800 + 783)  check("pin_783_rgb",        32'(b_rgb),   32'h27F);
      if (t == 35 * 800 + 784)  check("pin_784_rgb",        32'(b_rgb),   32'd0);
      if (t == 70)              check("pin_sml_fs",         32'(s_fs),    32'd1);
      if (t == 69)              check("pin_sml_no_fs",      32'(s_fs),    32'd0);

      // Per-line duty counts on the full-size instance.
      hb_now = t % 800;
      vb_now = (t / 800) % 525;
      if (hb_now == 0) begin
         hs_low_cnt = 0;
         req_cnt    = 0;
      end
      if (!b_hsync) hs_low_cnt++;
      if (b_req)    req_cnt++;
      if (hb_now == 799 && !rst) begin
         check("line_hsync_low", 32'(hs_low_cnt), 32'd96);
         check("line_req_cnt", 32'(req_cnt), (vb_now >= 35 && vb_now < 515) ? 32'd640 : 32'd0);
      end
   end

   // Full-size pix_data is the previous clock's requested column; tiny-mode data is random.
   task automatic step(input logic rst_v);
      exp_t e;
      e = model(m_big, t);
      @(posedge clk);
      #1;
      pix_big = {2'b00, e.px};
      pix_sml = 12'($urandom);
      rst     = rst_v;
   endtask

   initial begin
      rst     = 1'b1;
      pix_big = 12'h000;
      pix_sml = 12'h000;
      repeat (5) step(1'b1);
      repeat (30400) step(1'b0);
      // Reset the tiny instance mid-frame at (h, v) = (5, 3).
      for (int i = 0; i < 70 && (t % 70) != 35; i++) step(1'b0);
      step(1'b1);
      repeat (300) step(1'b0);
      for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0);
      step(1'b0);
      repeat (200) step(1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- 640x480@60 Hz VGA timing generator; sits directly upstream of the picture/display stage.
- Produces hsync/vsync, pixel coordinates (pix_x, pix_y) issued one clock ahead of the active video window, and a data request strobe.
- Accepts the 12-bit pixel colour returned by the display stage and drives gated RGB to the pins.

Parameters:
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
H_TOTAL, 800, clocks per line (= sum of the four above)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_VALID, 480, active lines
V_FRONT, 10, vertical front porch
V_TOTAL, 525, lines per frame

Ports:
vga_clk  in  1  25.175/25 MHz pixel clock; single clock domain
rst  in  1  asynchronous, active-high reset
pix_data  in  12  RGB444 from display stage, valid one clock after the matching pix_x/pix_y
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
rgb  out  12  RGB444 to DAC/pins; zero outside the active window
pix_x  out  10  requested column 0..639; 10'h3FF when not requesting
pix_y  out  10  requested row 0..479; 10'h3FF when not requesting
pix_req  out  1  high when pix_x/pix_y carry a valid request
frame_start  out  1  one-clock pulse at the first clock of each frame

Behaviour:
- Interface decided: one clock, vga_clk; reset rst is asynchronous and active-high.
- h_cnt (10b) increments every clock and wraps H_TOTAL-1 -> 0.
- v_cnt (10b) increments when h_cnt == H_TOTAL-1 and wraps V_TOTAL-1 -> 0 on that same edge.
- Reset: h_cnt = 0, v_cnt = 0, frame_start = 0.
  - Combinational outputs follow from the counters: hsync = 0, vsync = 0, pix_req = 0, pix_x = pix_y = 10'h3FF, rgb = 0.
  - Reset mid-line or mid-frame restarts timing at (0,0) immediately. There is no partial-frame recovery.
- hsync = 0 when h_cnt < H_SYNC, else 1. vsync = 0 when v_cnt < V_SYNC, else 1.
- Active window (rgb_valid):
  - h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) = [144, 784).
  - v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID) = [35, 515).
- Request window (pix_req): the same window shifted one clock earlier horizontally, h_cnt in [143, 783). Vertical range is unchanged.
  - pix_x = h_cnt - 143.
  - pix_y = v_cnt - 35.
  - Both are 10-bit unsigned and only evaluated inside the window. Outside it both read 10'h3FF.
- Latency contract: the display stage registers its result once. pix_data sampled on the clock after pix_req corresponds to the previous (pix_x, pix_y).
- rgb = rgb_valid ? pix_data : 12'h000, combinational. No extra pipeline stage.
- frame_start register:
  - Set to 1 on the edge where h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1, so it is high during the (0,0) clock.
  - Cleared on the next clock.
  - Not asserted on the first frame after reset.
- Boundaries:
  - Line end at h_cnt = 799: next is 0.
  - Frame end at (799, 524): next is (0, 0).
  - The last request in a line is pix_x = 639 at h_cnt = 782. At h_cnt = 783 pix_req = 0 while rgb_valid = 1.
- All counter comparisons use the parameters. Changing the parameters to another mode must need no RTL edits.

Optional Feature:
FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt [7:0], reset 0.
  - frame_cnt increments on the same edge that sets frame_start and wraps 255 -> 0.
  - Intended as the frame index for animation sequencing.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset check: hold rst = 1 for 5 clocks, then release.
  - During reset: hsync = 0, vsync = 0, pix_req = 0, pix_x = 10'h3FF, rgb = 0.
  - First rising edge after release: h_cnt = 1.
- Line timing:
  - hsync low for exactly 96 clocks per 800-clock line.
  - pix_req high for exactly 640 clocks per active line.
  - pix_x sequence runs 0..639 contiguously starting at h_cnt = 143.
- Frame timing:
  - vsync low for exactly 2×800 = 1600 clocks per frame.
  - frame_start pulses every 420000 clocks, width 1.
  - pix_y runs 0..479.
- Latency/gating:
  - Drive pix_data = {2'b0, pix_x} delayed by one clock.
  - rgb equals the expected column at every active clock, including the column 639 → rgb 12'h27F at h_cnt = 783.
  - rgb = 0 at h_cnt = 784 and at v_cnt = 34 or 515.
- Mid-frame reset:
  - Assert rst at (h, v) = (400, 200) for 1 clock.
  - Counters return to (0, 0), outputs return to reset values, and the next frame_start occurs 420000 clocks later.
- FRAME_CNT_EN: run 257 frames; frame_cnt reaches 255, then wraps to 0, then 1, each change coinciding with frame_start.
